// File: rtl/mic_frame_pkg.sv
// Shared types, constants and elaboration helpers for the
// multi-channel mic frame writer into the Nios dual-port RAM.
package mic_frame_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    WRITE      = 2'd2
  } state_e;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_LO   = 4'h3;

  function automatic int wpf(input int nch, input int sw);
    return (nch * sw + 31) / 32;
  endfunction

  function automatic int half_base(input logic h, input int aw);
    return h ? (1 << (aw - 1)) : 0;
  endfunction

  function automatic bit sw_ok(input int sw);
    return (sw == 16) || (sw == 32);
  endfunction

  function automatic bit cfg_ok(input int nch, input int sw,
                                input int aw, input int fpb);
    return sw_ok(sw) && (nch >= 1) && (nch <= 16) && (aw >= 2) &&
           (fpb >= 1) && (fpb * wpf(nch, sw) <= (1 << (aw - 1)));
  endfunction

endpackage

// File: rtl/mic_frame_ram_writer_packer.sv
// Frame register plus word selector: turns one latched frame
// into 32-bit RAM words and their byte lanes.
module mic_frame_packer
  import mic_frame_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int WPF      = 2,
  parameter int WI_W     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_i,
  input  logic [NUM_CH*SAMPLE_W-1:0] data_i,
  input  logic [WI_W-1:0]            widx_i,
  output logic [31:0]                wdata_o,
  output logic [3:0]                 be_o
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam bit ODD_HALF = (SAMPLE_W == 16) && (NUM_CH % 2 == 1);

  logic [FW-1:0]     frame_q;
  logic [FW-1:0]     src;
  logic [WPF*32-1:0] pad;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) frame_q <= '0;
    else if (load_i) frame_q <= data_i;
  end

  // word 0 is registered on the accept edge, before frame_q holds it
  assign src = load_i ? data_i : frame_q;

  always_comb begin
    pad = '0;
    pad[FW-1:0] = src;
  end

  assign wdata_o = pad[{widx_i, 5'd0} +: 32];
  assign be_o = (ODD_HALF && (widx_i == WI_W'(WPF - 1))) ? BE_LO : BE_FULL;

endmodule

// File: rtl/mic_frame_ram_writer.sv
// Mic frame capture into a ping-pong RAM split with level IRQ
// on half-buffer completion and a saturating overrun count.
module mic_frame_ram_writer
  import mic_frame_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int SAMPLE_W       = 16,
  parameter int ADDR_W         = 10,
  parameter int FRAMES_PER_BUF = 64
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       enable,
  input  logic                       smp_valid,
  output logic                       smp_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] smp_data,
  output logic [ADDR_W-1:0]          ram_address,
  output logic                       ram_chipselect,
  output logic                       ram_clken,
  output logic                       ram_write,
  output logic [31:0]                ram_writedata,
  output logic [3:0]                 ram_byteenable,
  output logic                       irq,
  input  logic                       irq_ack,
  output logic                       buf_sel,
  output logic [15:0]                overrun_cnt
);

  localparam int WPF  = wpf(NUM_CH, SAMPLE_W);
  localparam int WI_W = $clog2(WPF + 1);

  if (!cfg_ok(NUM_CH, SAMPLE_W, ADDR_W, FRAMES_PER_BUF)) begin : g_cfg_bad
    $error("mic_frame_ram_writer: illegal parameter set");
  end

  state_e              state_q, state_d;
  logic                hs, wr_next, last_w, done_buf;
  logic [WI_W-1:0]     widx_q, widx_d, nxt_widx;
  logic                half_q, half_d;
  logic [ADDR_W-1:0]   fidx_q, fidx_d;
  logic                irq_q, irq_d;
  logic                bsel_q, bsel_d;
  logic [15:0]         ovr_q, ovr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q;
  logic [31:0]         wd_q, pk_wd;
  logic [3:0]          be_q, pk_be;

  assign hs       = smp_valid & smp_ready;
  assign last_w   = (state_q == WRITE) && (widx_q == WI_W'(WPF - 1));
  assign done_buf = last_w && (fidx_q == ADDR_W'(FRAMES_PER_BUF - 1));
  assign nxt_widx = hs ? '0 : widx_q + WI_W'(1);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (enable) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (hs) state_d = WRITE;
        else if (!enable) state_d = IDLE;
      end
      WRITE:      if (last_w) state_d = enable ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    smp_ready = (state_q == WAIT_FRAME);
    wr_next   = hs || ((state_q == WRITE) && !last_w);
  end

  always_comb begin
    widx_d = wr_next ? nxt_widx : widx_q;
    half_d = half_q;
    fidx_d = fidx_q;
    if (state_q == IDLE) begin
      half_d = 1'b0;
      fidx_d = '0;
    end else if (done_buf) begin
      half_d = ~half_q;
      fidx_d = '0;
    end else if (last_w) begin
      fidx_d = fidx_q + ADDR_W'(1);
    end
    addr_d = ADDR_W'(half_base(half_q, ADDR_W)) +
             ADDR_W'(int'(fidx_q) * WPF) + ADDR_W'(nxt_widx);
  end

  // ack loses to a completion landing in the same cycle
  always_comb begin
    irq_d  = irq_q;
    bsel_d = bsel_q;
    ovr_d  = ovr_q;
    if (done_buf) begin
      irq_d  = 1'b1;
      bsel_d = half_q;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
    if (state_q == IDLE) ovr_d = '0;
    else if (done_buf && irq_q && !irq_ack && (ovr_q != 16'hFFFF))
      ovr_d = ovr_q + 16'd1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      widx_q <= '0;
      half_q <= 1'b0;
      fidx_q <= '0;
      irq_q  <= 1'b0;
      bsel_q <= 1'b0;
      ovr_q  <= '0;
      addr_q <= '0;
      cs_q   <= 1'b0;
      wd_q   <= '0;
      be_q   <= '0;
    end else begin
      widx_q <= widx_d;
      half_q <= half_d;
      fidx_q <= fidx_d;
      irq_q  <= irq_d;
      bsel_q <= bsel_d;
      ovr_q  <= ovr_d;
      cs_q   <= wr_next;
      addr_q <= wr_next ? addr_d : '0;
      wd_q   <= wr_next ? pk_wd : '0;
      be_q   <= wr_next ? pk_be : '0;
    end
  end

  mic_frame_packer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .WPF      (WPF),
    .WI_W     (WI_W)
  ) u_packer (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .load_i  (hs),
    .data_i  (smp_data),
    .widx_i  (nxt_widx),
    .wdata_o (pk_wd),
    .be_o    (pk_be)
  );

  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;
  assign ram_clken      = cs_q;
  assign ram_write      = cs_q;
  assign ram_writedata  = wd_q;
  assign ram_byteenable = be_q;
  assign irq            = irq_q;
  assign buf_sel        = bsel_q;
  assign overrun_cnt    = ovr_q;

endmodule

// File: tb/tb_mic_frame_ram_writer.sv
// Bench for mic_frame_ram_writer: directed table, corner
// sequences and random frames against a queue-based model.
module tb_mic_frame_ram_writer;

  logic        clk, rst_n;
  logic        enable, smp_valid, smp_ready;
  logic [63:0] smp_data;
  logic [9:0]  ram_address;
  logic        ram_chipselect, ram_clken, ram_write;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic        irq, irq_ack, buf_sel;
  logic [15:0] overrun_cnt;

  logic        b_enable, b_valid, b_ready;
  logic [47:0] b_data;
  logic [9:0]  b_addr;
  logic        b_cs, b_clken, b_write;
  logic [31:0] b_wd;
  logic [3:0]  b_be;
  logic        b_irq, b_ack, b_bsel;
  logic [15:0] b_ovr;

  int vec = 0;
  int bad = 0;

  logic [45:0] actq[$];
  logic [45:0] expq[$];

  int m_half, m_fidx, m_irq, m_bsel, m_ovr;

  typedef struct {
    logic [63:0] frame;
    logic [9:0]  a0;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          ack;
    bit          irq;
    bit          bsel;
    logic [15:0] ovr;
  } vec_t;

  vec_t tbl[11];

  mic_frame_ram_writer #(
    .NUM_CH(4), .SAMPLE_W(16), .ADDR_W(10), .FRAMES_PER_BUF(4)
  ) u_dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (enable),
    .smp_valid      (smp_valid),
    .smp_ready      (smp_ready),
    .smp_data       (smp_data),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_clken      (ram_clken),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .irq            (irq),
    .irq_ack        (irq_ack),
    .buf_sel        (buf_sel),
    .overrun_cnt    (overrun_cnt)
  );

  mic_frame_ram_writer #(
    .NUM_CH(3), .SAMPLE_W(16), .ADDR_W(10), .FRAMES_PER_BUF(4)
  ) u_dut3 (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (b_enable),
    .smp_valid      (b_valid),
    .smp_ready      (b_ready),
    .smp_data       (b_data),
    .ram_address    (b_addr),
    .ram_chipselect (b_cs),
    .ram_clken      (b_clken),
    .ram_write      (b_write),
    .ram_writedata  (b_wd),
    .ram_byteenable (b_be),
    .irq            (b_irq),
    .irq_ack        (b_ack),
    .buf_sel        (b_bsel),
    .overrun_cnt    (b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (ram_write === 1'b1)
      actq.push_back({ram_address, ram_writedata, ram_byteenable});

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    chk(nm, {ram_write, ram_chipselect, ram_clken, smp_ready,
             ram_address, ram_writedata, ram_byteenable},
        {3'b111, 1'b0, a, d, be});
  endtask

  task automatic model_reset();
    m_half = 0; m_fidx = 0; m_irq = 0; m_bsel = 0; m_ovr = 0;
  endtask

  task automatic model_idle();
    m_half = 0; m_fidx = 0; m_ovr = 0;
  endtask

  task automatic model_accept(input logic [63:0] d, input bit ack);
    for (int k = 0; k < 2; k++)
      expq.push_back({10'(m_half * 512 + m_fidx * 2 + k),
                      d[k*32 +: 32], 4'hF});
    m_fidx++;
    if (m_fidx == 4) begin
      m_fidx = 0;
      if (m_irq != 0 && !ack && m_ovr < 65535) m_ovr++;
      m_irq  = 1;
      m_bsel = m_half;
      m_half = 1 - m_half;
    end else if (ack) begin
      m_irq = 0;
    end
  endtask

  task automatic chk_status(input string nm);
    chk(nm, {irq, buf_sel, overrun_cnt},
        {m_irq[0], m_bsel[0], 16'(m_ovr)});
  endtask

  task automatic drain();
    logic [45:0] a, e;
    while (actq.size() != 0 && expq.size() != 0) begin
      a = actq.pop_front();
      e = expq.pop_front();
      chk("mdl_write", 64'(a), 64'(e));
    end
    chk("write_count", 64'(actq.size()), 64'(expq.size()));
    actq.delete();
    expq.delete();
  endtask

  // handshake now or after ready rises; returns in the first write cycle
  task automatic send(input logic [63:0] d, input bit ack);
    int n = 0;
    smp_data  = d;
    smp_valid = 1'b1;
    while (smp_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("hs_ready", 64'(smp_ready), 64'd1);
    if (smp_ready === 1'b1) model_accept(d, ack);
    step();
    smp_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{64'h8888_7777_6666_5555, 10'd2,   32'h66665555, 32'h88887777, 0, 0, 0, 16'd0};
    tbl[1]  = '{64'hDEAD_BEEF_CAFE_F00D, 10'd4,   32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 0, 16'd0};
    tbl[2]  = '{64'h0123_4567_89AB_CDEF, 10'd6,   32'h89ABCDEF, 32'h01234567, 0, 1, 0, 16'd0};
    tbl[3]  = '{64'hFFFF_0000_A5A5_5A5A, 10'd512, 32'hA5A55A5A, 32'hFFFF0000, 0, 1, 0, 16'd0};
    tbl[4]  = '{64'h1357_9BDF_2468_ACE0, 10'd514, 32'h2468ACE0, 32'h13579BDF, 0, 1, 0, 16'd0};
    tbl[5]  = '{64'h0000_0001_8000_0000, 10'd516, 32'h80000000, 32'h00000001, 0, 1, 0, 16'd0};
    tbl[6]  = '{64'h7FFF_8001_00FF_FF00, 10'd518, 32'h00FFFF00, 32'h7FFF8001, 0, 1, 1, 16'd1};
    tbl[7]  = '{64'hAAAA_5555_5555_AAAA, 10'd0,   32'h5555AAAA, 32'hAAAA5555, 0, 1, 1, 16'd1};
    tbl[8]  = '{64'h1111_2222_3333_4444, 10'd2,   32'h33334444, 32'h11112222, 0, 1, 1, 16'd1};
    tbl[9]  = '{64'h0F0F_F0F0_C3C3_3C3C, 10'd4,   32'hC3C33C3C, 32'h0F0FF0F0, 0, 1, 1, 16'd1};
    tbl[10] = '{64'h9999_AAAA_BBBB_CCCC, 10'd6,   32'hBBBBCCCC, 32'h9999AAAA, 1, 1, 0, 16'd1};

    rst_n = 1'b0; enable = 1'b1; smp_valid = 1'b0; smp_data = '0;
    irq_ack = 1'b0;
    b_enable = 1'b1; b_valid = 1'b0; b_data = '0; b_ack = 1'b0;
    model_reset();

    repeat (3) step();
    chk("reset_ram", {ram_address, ram_chipselect, ram_clken, ram_write,
                      ram_writedata, ram_byteenable}, 64'd0);
    chk("reset_ctl", {smp_ready, irq, buf_sel, overrun_cnt}, 64'd0);
    rst_n = 1'b1;
    chk("ready_at_release", 64'(smp_ready), 64'd0);
    step();
    step();
    chk("ready_2cyc", 64'(smp_ready), 64'd1);

    // three-channel instance: odd channel count pads the last word
    b_data  = 48'hCCCC_BBBB_AAAA;
    b_valid = 1'b1;
    chk("b_ready", 64'(b_ready), 64'd1);
    step();
    b_valid = 1'b0;
    chk("b_w0", {b_write, b_cs, b_clken, b_addr, b_wd, b_be},
        {3'b111, 10'd0, 32'hBBBBAAAA, 4'hF});
    step();
    chk("b_w1", {b_write, b_cs, b_clken, b_addr, b_wd, b_be},
        {3'b111, 10'd1, 32'h0000CCCC, 4'h3});
    step();
    chk("b_done", {b_ready, b_write, b_irq, b_bsel, b_ovr},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});

    send(64'h4444_3333_2222_1111, 1'b0);
    chk_word("f0_w0", 10'd0, 32'h22221111, 4'hF);
    step();
    chk_word("f0_w1", 10'd1, 32'h44443333, 4'hF);
    step();
    chk("f0_ready_back", {smp_ready, ram_write}, 64'b10);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].frame, tbl[i].ack);
      chk_word("tbl_w0", tbl[i].a0, tbl[i].w0, 4'hF);
      step();
      irq_ack = tbl[i].ack;
      chk_word("tbl_w1", tbl[i].a0 + 10'd1, tbl[i].w1, 4'hF);
      step();
      irq_ack = 1'b0;
      chk("tbl_stat", {smp_ready, irq, buf_sel, overrun_cnt},
          {1'b1, tbl[i].irq, tbl[i].bsel, tbl[i].ovr});
    end
    drain();
    chk_status("mdl_stat_tbl");

    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    m_irq = 0;
    chk("ack_clear", {irq, overrun_cnt}, {1'b0, 16'd1});

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        irq_ack = ($urandom_range(0, 3) == 0);
        step();
        if (irq_ack) m_irq = 0;
        irq_ack = 1'b0;
      end
      send({$urandom, $urandom}, 1'b0);
      step();
      step();
      drain();
      chk_status("rnd_stat");
    end

    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    m_irq = 0;
    enable = 1'b0;
    step();
    step();
    chk("idle_clr", {smp_ready, irq, overrun_cnt}, 64'd0);
    model_idle();
    enable = 1'b1;
    step();
    send(64'h0000_0001_0000_0002, 1'b0);
    step(); step();
    send(64'h0000_0003_0000_0004, 1'b0);
    step(); step();
    send(64'h5555_6666_7777_8888, 1'b0);
    enable = 1'b0;
    chk_word("drop_w0", 10'd4, 32'h77778888, 4'hF);
    step();
    chk_word("drop_w1", 10'd5, 32'h55556666, 4'hF);
    step();
    chk("drop_idle", {smp_ready, ram_write, irq}, 64'd0);
    step();
    chk("drop_ovr", {irq, overrun_cnt}, 64'd0);
    model_idle();
    drain();
    enable = 1'b1;
    step();
    send(64'h0000_0000_1234_ABCD, 1'b0);
    chk_word("reen_w0", 10'd0, 32'h1234ABCD, 4'hF);
    step();
    step();
    drain();
    chk_status("reen_stat");

    send(64'hFEED_FACE_0BAD_BEEF, 1'b0);
    chk("pre_rst_write", 64'(ram_write), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {ram_write, ram_chipselect, ram_clken}, 64'd0);
    step();
    step();
    chk("no_write_rst", 64'(actq.size()), 64'd0);
    expq.delete();
    model_reset();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
